// File: rtl/pe_linear_output_buffer.sv
// Gathers pOUTPUT_PARALLEL-wide feature groups into a full frame, then streams
// the frame out as pOUT_WORD-wide beats with valid/ready handshaking.
module pe_linear_output_buffer #(
  parameter int pOUT_FEATURE     = 128,
  parameter int pOUTPUT_PARALLEL = 4,
  parameter int pDATA_WIDTH      = 8,
  parameter int pOUT_WORD        = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [pOUTPUT_PARALLEL*pDATA_WIDTH-1:0] in_data,
  output logic                                  in_ready,
  output logic                                  out_valid,
  output logic [pOUT_WORD*pDATA_WIDTH-1:0]      out_data,
  input  logic                                  out_ready,
  output logic                                  out_last,
  output logic                                  frame_done,
  output logic                                  overflow
);

  localparam int G  = pOUT_FEATURE / pOUTPUT_PARALLEL;
  localparam int B  = pOUT_FEATURE / pOUT_WORD;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);
  localparam logic [BW-1:0] B_LAST = BW'(B - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [GW-1:0]  grp_cnt;
  logic [BW-1:0]  beat_cnt;
  logic           wr_en, rd_en, grp_last, beat_last;

  logic [pOUT_FEATURE-1:0][pDATA_WIDTH-1:0]     mem;
  logic [B-1:0][pOUT_WORD*pDATA_WIDTH-1:0]      beats;
  logic [pOUTPUT_PARALLEL-1:0][pDATA_WIDTH-1:0] in_lanes;

  // Reshaped views: feature 0 sits in the LSBs of both the input group and beat 0.
  assign in_lanes  = in_data;
  assign beats     = mem;

  assign wr_en     = in_valid && (state == FILL);
  assign rd_en     = (state == DRAIN) && out_ready;
  assign grp_last  = (grp_cnt == G_LAST);
  assign beat_last = (beat_cnt == B_LAST);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = beats[beat_cnt];
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (wr_en && grp_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = beat_last;
        if (rd_en && beat_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      grp_cnt    <= '0;
      beat_cnt   <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= rd_en && beat_last;
      if (in_valid && (state != FILL)) overflow <= 1'b1;
      if (wr_en)    grp_cnt  <= grp_last  ? '0 : grp_cnt + 1'b1;
      if (rd_en)    beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
    end
  end

  // Storage is fully rewritten every frame before it is read, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int g = 0; g < G; g++)
      if (wr_en && (grp_cnt == GW'(g)))
        mem[g*pOUTPUT_PARALLEL +: pOUTPUT_PARALLEL] <= in_lanes;
  end

endmodule

// File: tb/tb_pe_linear_output_buffer.sv
// Directed/randomized bench for pe_linear_output_buffer against a frame-level
// reference model; a second instance covers the single-beat configuration.
module tb_pe_linear_output_buffer;
  localparam int F = 128, P = 4, DW = 8, W = 8;
  localparam int G = F / P, B = F / W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, in_valid, in_ready, out_valid, out_ready, out_last, frame_done, overflow;
  logic [P*DW-1:0] in_data;
  logic [W*DW-1:0] out_data;

  logic            rst1, in_valid1, in_ready1, out_valid1, out_ready1, out_last1, frame_done1, overflow1;
  logic [7:0]      in_data1;
  logic [127:0]    out_data1;

  pe_linear_output_buffer #(.pOUT_FEATURE(F), .pOUTPUT_PARALLEL(P), .pDATA_WIDTH(DW), .pOUT_WORD(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_last(out_last),
    .frame_done(frame_done), .overflow(overflow));

  pe_linear_output_buffer #(.pOUT_FEATURE(16), .pOUTPUT_PARALLEL(1), .pDATA_WIDTH(8), .pOUT_WORD(16)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1), .out_last(out_last1),
    .frame_done(frame_done1), .overflow(overflow1));

  int n_cmp = 0, n_bad = 0;
  int dut_acc = 0, dut_fd = 0;

  // Reference model: phase, position within phase, expected frame contents.
  bit                   m_fill, m_fd, m_ovf;
  int                   m_cnt;
  logic [F-1:0][DW-1:0] m_mem;
  logic [15:0][7:0]     exp1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    rst = 1'b0;
    m_fill = 1'b1; m_cnt = 0; m_fd = 1'b0; m_ovf = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
  endtask

  // One clock cycle: check DUT against model, then advance both.
  task automatic step(input bit iv, input logic [31:0] d, input bit ordy);
    bit fd_next = 1'b0;
    in_valid = iv; in_data = d; out_ready = ordy;
    check("in_ready", in_ready, m_fill);
    check("out_valid", out_valid, !m_fill);
    check("frame_done", frame_done, m_fd);
    check("overflow", overflow, m_ovf);
    if (!m_fill) begin
      check("out_data", out_data, m_mem[m_cnt*W +: W]);
      check("out_last", out_last, m_cnt == B-1);
    end
    if (out_valid && ordy) dut_acc++;
    if (frame_done) dut_fd++;
    if (m_fill) begin
      if (iv) begin
        m_mem[m_cnt*P +: P] = d;
        m_cnt++;
        if (m_cnt == G) begin m_fill = 1'b0; m_cnt = 0; end
      end
    end else begin
      if (iv) m_ovf = 1'b1;
      if (ordy) begin
        m_cnt++;
        if (m_cnt == B) begin m_fill = 1'b1; m_cnt = 0; fd_next = 1'b1; end
      end
    end
    tick();
    m_fd = fd_next;
  endtask

  task automatic fill_random();
    for (int g = 0; g < G; g++) step(1'b1, $urandom, 1'b1);
  endtask

  task automatic drain_all(input string tag);
    int i = 0;
    dut_acc = 0;
    while (!m_fill && i < 200) begin step(1'b0, '0, 1'b1); i++; end
    check({tag, "_drain_bound"}, i < 200, 1);
    check({tag, "_beats"}, dut_acc, B);
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    do_reset();
    rst1 = 1'b0;
    check("rst1_in_ready", in_ready1, 1);
    check("rst1_overflow", overflow1, 0);

    // Counting-pattern frame.
    for (int g = 0; g < G; g++)
      step(1'b1, {8'(4*g+3), 8'(4*g+2), 8'(4*g+1), 8'(4*g)}, 1'b1);
    drain_all("count");

    // Backpressure 1,0,0,1 during drain.
    fill_random();
    begin
      int i = 0;
      dut_acc = 0;
      while (!m_fill && i < 200) begin step(1'b0, '0, (i % 4 == 0) || (i % 4 == 3)); i++; end
      check("bp_drain_bound", i < 200, 1);
      check("bp_beats", dut_acc, B);
      step(1'b0, '0, 1'b0);
    end

    // Writes during drain: sticky overflow, data untouched.
    fill_random();
    begin
      int i = 0;
      while (!m_fill && i < 200) begin step(1'b1, 32'hFFFF_FFFF, 1'($urandom_range(0, 1))); i++; end
      check("ovf_drain_bound", i < 200, 1);
    end
    step(1'b0, '0, 1'b0);
    fill_random();
    drain_all("post_ovf");
    check("ovf_sticky", overflow, 1);

    // Reset mid-fill and mid-drain.
    for (int g = 0; g < 10; g++) step(1'b1, $urandom, 1'b1);
    do_reset();
    fill_random();
    for (int b = 0; b < 3; b++) step(1'b0, '0, 1'b1);
    do_reset();
    fill_random();
    drain_all("post_rst");

    // Back-to-back frames with in_valid held high.
    dut_fd = 0;
    for (int i = 0; i < 2*(G+B)+1; i++) step(1'b1, $urandom, 1'b1);
    check("b2b_frame_done_pulses", dut_fd, 2);
    in_valid = 1'b0;

    // Single-beat configuration.
    for (int f = 0; f < 16; f++) begin
      in_valid1 = 1'b1; in_data1 = 8'($urandom); exp1[f] = in_data1;
      check("sw_in_ready", in_ready1, 1);
      tick();
    end
    in_valid1 = 1'b0;
    check("sw_out_valid", out_valid1, 1);
    check("sw_out_last", out_last1, 1);
    check("sw_out_data", out_data1, exp1);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("sw_frame_done", frame_done1, 1);
    check("sw_in_ready_back", in_ready1, 1);
    check("sw_out_valid_low", out_valid1, 0);
    tick();
    check("sw_frame_done_pulse", frame_done1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pe_linear_output_buffer.md
PE_LINEAR_OUTPUT_BUFFER -- requirements
Module: pe_linear_output_buffer

Interface
REQ-001 SHALL have parameter pOUT_FEATURE, default 128, total output features per frame.
REQ-002 SHALL have parameter pOUTPUT_PARALLEL, default 4, features delivered per input beat.
REQ-003 SHALL have parameter pDATA_WIDTH, default 8, bits per quantized feature.
REQ-004 SHALL have parameter pOUT_WORD, default 8, features per output beat; pOUT_FEATURE divisible by pOUTPUT_PARALLEL and by pOUT_WORD.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  quantized group present, driven from upstream controller buffer_en.
REQ-008 SHALL have port in_data  input  pOUTPUT_PARALLEL*pDATA_WIDTH  feature group; element 0 in bits [pDATA_WIDTH-1:0].
REQ-009 SHALL have port in_ready  output  1  buffer accepting groups.
REQ-010 SHALL have port out_valid  output  1  output beat present.
REQ-011 SHALL have port out_data  output  pOUT_WORD*pDATA_WIDTH  output beat; lowest feature index in LSBs.
REQ-012 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-013 SHALL have port out_last  output  1  final beat of frame.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after final beat accepted.
REQ-015 SHALL have port overflow  output  1  sticky: group arrived while in_ready low.

Function
REQ-016 SHALL hold storage of pOUT_FEATURE x pDATA_WIDTH, a group counter 0..G-1 (G=pOUT_FEATURE/pOUTPUT_PARALLEL), a beat counter 0..B-1 (B=pOUT_FEATURE/pOUT_WORD).
REQ-017 SHALL implement two states, FILL and DRAIN; in_ready = (state==FILL), out_valid = (state==DRAIN), both decoded from registered state.
REQ-018 In FILL, in_valid=1 SHALL write in_data element k to feature index grp_cnt*pOUTPUT_PARALLEL+k and increment grp_cnt.
REQ-019 On the write with grp_cnt==G-1, grp_cnt SHALL wrap to 0 and state SHALL go to DRAIN next cycle (out_valid high the cycle after the last write).
REQ-020 In DRAIN, out_data SHALL present features beat_cnt*pOUT_WORD .. beat_cnt*pOUT_WORD+pOUT_WORD-1; out_data and out_valid SHALL stay stable while out_ready=0.
REQ-021 out_valid&&out_ready SHALL advance beat_cnt; out_last = DRAIN && beat_cnt==B-1.
REQ-022 Accepted beat with beat_cnt==B-1 SHALL wrap beat_cnt to 0, return to FILL next cycle, and assert frame_done exactly one cycle (the cycle in_ready returns high).
REQ-023 in_valid while in_ready=0 SHALL not modify storage or counters and SHALL set overflow, held until rst.
REQ-024 Storage contents SHALL not be cleared between frames; each frame fully overwrites before draining.
REQ-025 Throughput: G write cycles + B drain cycles per frame minimum; no bubble required between FILL->DRAIN or DRAIN->FILL beyond the single registered transition.

Reset
REQ-026 rst=1 SHALL force state FILL, grp_cnt=0, beat_cnt=0, in_ready=1, out_valid=0, out_last=0, frame_done=0, overflow=0; out_data don't-care.
REQ-027 rst asserted mid-FILL or mid-DRAIN SHALL abandon the partial frame; first group after rst deasserts SHALL land at feature index 0.
REQ-028 Storage SHALL not require reset.

Verification
REQ-029 Fill: 32 groups, group g = {4g+3,4g+2,4g+1,4g} bytes, out_ready=1 -> out_valid rises cycle after 32nd write; 16 beats, beat b bytes = 8b..8b+7; out_last on beat 15; frame_done one cycle after beat 15.
REQ-030 Backpressure: out_ready toggled 1,0,0,1 repeating during DRAIN -> out_data unchanged across stalled cycles, exactly 16 accepted beats, no duplicated/skipped index.
REQ-031 Overflow: in_valid=1 during DRAIN with data 0xFF -> overflow=1 and stays; drained data unchanged; next frame still starts at index 0.
REQ-032 Reset mid-frame: 10 groups written, rst for 1 cycle, then 32 fresh groups -> drained frame equals fresh data only, overflow=0.
REQ-033 Back-to-back frames: in_valid held high continuously with out_ready=1 -> groups accepted only while in_ready=1; two complete frames drained correctly; frame_done pulses twice.
REQ-034 Parameter sweep: pOUTPUT_PARALLEL=1, pOUT_WORD=pOUT_FEATURE=16 -> 16 writes, single beat with out_last=1 on it.
